// File: rtl/reduce_pkg.sv
// Shared types and identity/saturation helpers for the vector reduction engine.
package reduce_pkg;

  typedef enum logic [2:0] {
    OpSum = 3'd0,
    OpOr  = 3'd1,
    OpAnd = 3'd2,
    OpXor = 3'd3,
    OpMin = 3'd4,
    OpMax = 3'd5
  } reduce_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_t;

  // Helpers return 64-bit sign-extended values; callers truncate to their width.
  function automatic logic signed [63:0] sat_max(int unsigned bits);
    return (64'sd1 <<< (bits - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(int unsigned bits);
    return -(64'sd1 <<< (bits - 1));
  endfunction

  function automatic logic signed [63:0] identity(reduce_op_t op, int unsigned bits);
    case (op)
      OpAnd:   return -64'sd1;
      OpMin:   return sat_max(bits);
      OpMax:   return sat_min(bits);
      default: return 64'sd0;
    endcase
  endfunction

endpackage

// File: rtl/reduce_lane_tree.sv
// Folds one chunk of LANES elements into the running accumulator for the latched op.
// With REDUCE_ARGIDX_EN defined, also tracks the index of the selected MIN/MAX element.
module reduce_lane_tree
  import reduce_pkg::*;
#(
  parameter int unsigned BITS  = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned AW    = 14,
  parameter int unsigned IW    = 6
) (
  input  reduce_op_t              op,
  input  logic signed [AW-1:0]    acc,
  input  logic signed [BITS-1:0]  elems [LANES-1:0],
`ifdef REDUCE_ARGIDX_EN
  input  logic [IW-1:0]           base,
  input  logic [IW-1:0]           idx,
  output logic [IW-1:0]           idx_next,
`endif
  output logic signed [AW-1:0]    acc_next
);

  logic signed [AW-1:0] ext;

  // Non-SUM ops keep the accumulator sign-extended from BITS, so the low bits are the result.
  always_comb begin
    acc_next = acc;
    ext      = '0;
`ifdef REDUCE_ARGIDX_EN
    idx_next = idx;
`endif
    for (int l = 0; l < LANES; l++) begin
      ext = AW'(elems[l]);
      case (op)
        OpSum: acc_next = acc_next + ext;
        OpOr:  acc_next = acc_next | ext;
        OpAnd: acc_next = acc_next & ext;
        OpXor: acc_next = acc_next ^ ext;
        OpMin: begin
          if (ext < acc_next) begin
            acc_next = ext;
`ifdef REDUCE_ARGIDX_EN
            idx_next = base + IW'(l);
`endif
          end
        end
        OpMax: begin
          if (ext > acc_next) begin
            acc_next = ext;
`ifdef REDUCE_ARGIDX_EN
            idx_next = base + IW'(l);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vector_reduce_engine.sv
// Multi-lane signed vector reducer: SUM (saturating), OR, AND, XOR, MIN, MAX.
// Define REDUCE_ARGIDX_EN to add the out_idx port (MIN/MAX element index).
module vector_reduce_engine
  import reduce_pkg::*;
#(
  parameter int unsigned BITS  = 8,
  parameter int unsigned N     = 64,
  parameter int unsigned LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [BITS-1:0] in [N-1:0],
  input  logic [2:0]             op,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic signed [BITS-1:0] out,
  output logic                   ovf,
`ifdef REDUCE_ARGIDX_EN
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_idx,
`endif
  output logic                   bad_op
);

  localparam int unsigned K  = N / LANES;
  localparam int unsigned CW = $clog2(K) + 1;
  localparam int unsigned AW = BITS + $clog2(N);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [AW-1:0] SatHi = AW'(sat_max(BITS));
  localparam logic signed [AW-1:0] SatLo = AW'(sat_min(BITS));

  state_t                 state_q;
  reduce_op_t             op_q;
  logic [CW-1:0]          cnt_q;
  logic signed [AW-1:0]   acc_q, acc_next;
  logic signed [BITS-1:0] vec_q [N-1:0];
  logic signed [BITS-1:0] chunk [LANES-1:0];
  logic                   busy_q, done_q, ovf_q, bad_q;
  logic signed [BITS-1:0] out_q, res;
  logic                   res_ovf;
  logic                   accept, last;
  logic signed [63:0]     ident;

  assign accept = start && (state_q != StRun);
  assign last   = (cnt_q == CW'(K - 1));
  assign ident  = identity(reduce_op_t'(op), BITS);

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      chunk[l] = vec_q[IW'(int'(cnt_q) * LANES + l)];
    end
  end

`ifdef REDUCE_ARGIDX_EN
  logic [IW-1:0] idx_q, idx_next, idx_q_out, base_idx;
  assign base_idx = IW'(int'(cnt_q) * LANES);
`endif

  reduce_lane_tree #(
    .BITS  (BITS),
    .LANES (LANES),
    .AW    (AW),
    .IW    (IW)
  ) u_tree (
    .op       (op_q),
    .acc      (acc_q),
    .elems    (chunk),
`ifdef REDUCE_ARGIDX_EN
    .base     (base_idx),
    .idx      (idx_q),
    .idx_next (idx_next),
`endif
    .acc_next (acc_next)
  );

  // Final value for the last chunk: clamp SUM, zero for reserved opcodes.
  always_comb begin
    res     = acc_next[BITS-1:0];
    res_ovf = 1'b0;
    case (op_q)
      OpSum: begin
        if (acc_next > SatHi) begin
          res     = SatHi[BITS-1:0];
          res_ovf = 1'b1;
        end else if (acc_next < SatLo) begin
          res     = SatLo[BITS-1:0];
          res_ovf = 1'b1;
        end
      end
      OpOr, OpAnd, OpXor, OpMin, OpMax: ;
      default: res = '0;
    endcase
  end

  // Captured operand needs no reset; it is always rewritten before use.
  always_ff @(posedge clk) begin
    if (accept) vec_q <= in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= OpSum;
      cnt_q     <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
      bad_q     <= 1'b0;
`ifdef REDUCE_ARGIDX_EN
      idx_q     <= '0;
      idx_q_out <= '0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            state_q   <= StRun;
            op_q      <= reduce_op_t'(op);
            cnt_q     <= '0;
            acc_q     <= AW'(ident);
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            out_q     <= '0;
            ovf_q     <= 1'b0;
            bad_q     <= 1'b0;
`ifdef REDUCE_ARGIDX_EN
            idx_q     <= '0;
            idx_q_out <= '0;
`endif
          end
        end
        StRun: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 1'b1;
`ifdef REDUCE_ARGIDX_EN
          idx_q <= idx_next;
`endif
          if (last) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            out_q   <= res;
            ovf_q   <= res_ovf;
            bad_q   <= (op_q > OpMax);
`ifdef REDUCE_ARGIDX_EN
            idx_q_out <= (op_q == OpMin || op_q == OpMax) ? idx_next : '0;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign out    = out_q;
  assign ovf    = ovf_q;
  assign bad_op = bad_q;
`ifdef REDUCE_ARGIDX_EN
  assign out_idx = idx_q_out;
`endif

endmodule

// File: tb/tb_vector_reduce_engine.sv
// Bench for vector_reduce_engine (BITS=8, N=8, LANES=2): directed table, corner sequences,
// and random runs against a plain-arithmetic reference model.
module tb_vector_reduce_engine;

  localparam int BITS = 8;
  localparam int N = 8;
  localparam int LANES = 2;
  localparam int LAT = N / LANES + 1;

  logic clk = 1'b0;
  logic rst;
  logic signed [BITS-1:0] vin [N-1:0];
  logic [2:0] op_in;
  logic start;
  logic busy, done, ovf, bad_op;
  logic signed [BITS-1:0] out;
`ifdef REDUCE_ARGIDX_EN
  logic [2:0] out_idx;
`endif

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vector_reduce_engine #(
    .BITS  (BITS),
    .N     (N),
    .LANES (LANES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (vin),
    .op      (op_in),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .out     (out),
    .ovf     (ovf),
`ifdef REDUCE_ARGIDX_EN
    .out_idx (out_idx),
`endif
    .bad_op  (bad_op)
  );

  typedef struct packed {
    logic [63:0] v;   // element i in v[8*i +: 8]
    logic [2:0]  op;
    logic [7:0]  out;
    logic        ovf;
    logic        bad;
    logic [2:0]  idx;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: straight from the operation rules, no notion of lanes or chunks.
  task automatic model(input logic [63:0] v, input logic [2:0] o,
                       output int m_out, output int m_ovf, output int m_bad, output int m_idx);
    int e [N];
    int s;
    for (int i = 0; i < N; i++) e[i] = int'($signed(v[8*i +: 8]));
    m_out = 0; m_ovf = 0; m_bad = 0; m_idx = 0;
    case (o)
      3'd0: begin
        s = 0;
        for (int i = 0; i < N; i++) s += e[i];
        if (s > 127) begin m_out = 127; m_ovf = 1; end
        else if (s < -128) begin m_out = -128; m_ovf = 1; end
        else m_out = s;
      end
      3'd1, 3'd2, 3'd3: begin
        logic [7:0] r;
        r = (o == 3'd2) ? 8'hFF : 8'h00;
        for (int i = 0; i < N; i++) begin
          if (o == 3'd1) r = r | v[8*i +: 8];
          else if (o == 3'd2) r = r & v[8*i +: 8];
          else r = r ^ v[8*i +: 8];
        end
        m_out = int'($signed(r));
      end
      3'd4, 3'd5: begin
        m_out = e[0];
        for (int i = 1; i < N; i++) begin
          if ((o == 3'd4 && e[i] < m_out) || (o == 3'd5 && e[i] > m_out)) begin
            m_out = e[i];
            m_idx = i;
          end
        end
      end
      default: m_bad = 1;
    endcase
  endtask

  // Called at a negedge; returns at the first negedge with done high (or on timeout).
  task automatic do_run(input logic [63:0] v, input logic [2:0] o,
                        output int r_out, output int r_ovf, output int r_bad,
                        output int r_idx, output int r_lat);
    for (int i = 0; i < N; i++) vin[i] = v[8*i +: 8];
    op_in = o;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    r_lat = 1;
    chk("busy_after_start", int'(busy), 1);
    chk("done_low_after_start", int'(done), 0);
    for (int i = 0; i < N; i++) vin[i] = BITS'($urandom);
    op_in = 3'($urandom);
    while (!done && r_lat < 20) begin
      @(negedge clk);
      r_lat++;
    end
    r_out = int'(out);
    r_ovf = int'(ovf);
    r_bad = int'(bad_op);
`ifdef REDUCE_ARGIDX_EN
    r_idx = int'(out_idx);
`else
    r_idx = 0;
`endif
  endtask

  vec_t tbl [10];
  int a_out, a_ovf, a_bad, a_idx, a_lat;
  int m_out, m_ovf, m_bad, m_idx;
  logic [63:0] rv;
  logic [2:0] ro;

  initial begin
    tbl[0] = '{v: 64'h0807060504030201, op: 3'd0, out: 8'd36,  ovf: 1'b0, bad: 1'b0, idx: 3'd0};
    tbl[1] = '{v: 64'h6464646464646464, op: 3'd0, out: 8'h7F,  ovf: 1'b1, bad: 1'b0, idx: 3'd0};
    tbl[2] = '{v: 64'h9C9C9C9C9C9C9C9C, op: 3'd0, out: 8'h80,  ovf: 1'b1, bad: 1'b0, idx: 3'd0};
    tbl[3] = '{v: 64'h01090900F905F903, op: 3'd4, out: 8'hF9,  ovf: 1'b0, bad: 1'b0, idx: 3'd1};
    tbl[4] = '{v: 64'h01090900F905F903, op: 3'd5, out: 8'h09,  ovf: 1'b0, bad: 1'b0, idx: 3'd5};
    tbl[5] = '{v: 64'h01090900F905F903, op: 3'd0, out: 8'h0D,  ovf: 1'b0, bad: 1'b0, idx: 3'd0};
    tbl[6] = '{v: 64'h8001AA55C33CF00F, op: 3'd1, out: 8'hFF,  ovf: 1'b0, bad: 1'b0, idx: 3'd0};
    tbl[7] = '{v: 64'h8001AA55C33CF00F, op: 3'd2, out: 8'h00,  ovf: 1'b0, bad: 1'b0, idx: 3'd0};
    tbl[8] = '{v: 64'h8001AA55C33CF00F, op: 3'd3, out: 8'h7E,  ovf: 1'b0, bad: 1'b0, idx: 3'd0};
    tbl[9] = '{v: 64'h8001AA55C33CF00F, op: 3'd6, out: 8'h00,  ovf: 1'b0, bad: 1'b1, idx: 3'd0};

    rst = 1'b1;
    start = 1'b0;
    op_in = 3'd0;
    for (int i = 0; i < N; i++) vin[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_out", int'(out), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_bad_op", int'(bad_op), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 10; t++) begin
      do_run(tbl[t].v, tbl[t].op, a_out, a_ovf, a_bad, a_idx, a_lat);
      chk($sformatf("tbl%0d_latency", t), a_lat, LAT);
      chk($sformatf("tbl%0d_out", t), a_out, int'($signed(tbl[t].out)));
      chk($sformatf("tbl%0d_ovf", t), a_ovf, int'(tbl[t].ovf));
      chk($sformatf("tbl%0d_bad_op", t), a_bad, int'(tbl[t].bad));
`ifdef REDUCE_ARGIDX_EN
      chk($sformatf("tbl%0d_out_idx", t), a_idx, int'(tbl[t].idx));
`endif
      @(negedge clk);
    end

    // done and result held while idle in DONE
    repeat (3) @(negedge clk);
    chk("held_done", int'(done), 1);
    chk("held_bad_op", int'(bad_op), 1);

    // start pulsed mid-RUN is ignored
    for (int i = 0; i < N; i++) vin[i] = BITS'(i + 1);
    op_in = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) vin[i] = 8'sd100;
    op_in = 3'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_lat = 3;
    while (!done && a_lat < 20) begin
      @(negedge clk);
      a_lat++;
    end
    chk("midrun_latency", a_lat, LAT);
    chk("midrun_out", int'(out), 36);
    chk("midrun_ovf", int'(ovf), 0);

    // start in the first DONE cycle: new run accepted, done drops next edge (checked in do_run)
    do_run(64'h9C9C9C9C9C9C9C9C, 3'd0, a_out, a_ovf, a_bad, a_idx, a_lat);
    chk("b2b_latency", a_lat, LAT);
    chk("b2b_out", a_out, -128);
    chk("b2b_ovf", a_ovf, 1);

    // asynchronous reset mid-RUN
    for (int i = 0; i < N; i++) vin[i] = 8'sd100;
    op_in = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_out", int'(out), 0);
    chk("async_rst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_run(64'h0807060504030201, 3'd0, a_out, a_ovf, a_bad, a_idx, a_lat);
    chk("post_rst_latency", a_lat, LAT);
    chk("post_rst_out", a_out, 36);
    chk("post_rst_ovf", a_ovf, 0);

    // random runs against the reference model
    for (int r = 0; r < 40; r++) begin
      rv = {$urandom, $urandom};
      if (r % 4 == 0) rv = {8{rv[7:0]}};
      ro = 3'($urandom_range(0, 7));
      model(rv, ro, m_out, m_ovf, m_bad, m_idx);
      do_run(rv, ro, a_out, a_ovf, a_bad, a_idx, a_lat);
      chk($sformatf("rand%0d_op%0d_latency", r, ro), a_lat, LAT);
      chk($sformatf("rand%0d_op%0d_out", r, ro), a_out, m_out);
      chk($sformatf("rand%0d_op%0d_ovf", r, ro), a_ovf, m_ovf);
      chk($sformatf("rand%0d_op%0d_bad_op", r, ro), a_bad, m_bad);
`ifdef REDUCE_ARGIDX_EN
      chk($sformatf("rand%0d_op%0d_out_idx", r, ro), a_idx, m_idx);
`endif
      if (r % 3 == 0) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
